// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite widths, response codes and byte-strobe merge helper
package axi_lite_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] data,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] m;
        for (int b = 0; b < STRB_WIDTH; b++) m[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle with master and slave views
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    resp_t                 bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    resp_t                 rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave backed by NUM_REGS 32-bit read/write registers
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    axi_lite_if.slave              s,
    output logic [NUM_REGS*32-1:0] regs_o
);

    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int XW = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  rdy_en;
    logic                  aw_full;
    logic [XW-1:0]         aw_idx;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  aw_ok;
    logic [XW-1:0]         ar_idx;
    logic                  ar_ok;
    logic                  unused_ok;

    // Readies come only from registered state, so no valid/ready input reaches an output combinationally.
    assign s.awready = rdy_en && !aw_full;
    assign s.wready  = rdy_en && !w_full;
    assign s.arready = rdy_en && !s.rvalid;

    assign aw_hs  = s.awvalid && s.awready;
    assign w_hs   = s.wvalid && s.wready;
    assign ar_hs  = s.arvalid && s.arready;
    assign commit = aw_full && w_full && !s.bvalid;
    assign aw_ok  = aw_idx < XW'(NUM_REGS);
    assign ar_idx = s.araddr[ADDR_WIDTH-1:2];
    assign ar_ok  = ar_idx < XW'(NUM_REGS);

    assign unused_ok = ^{s.awprot, s.arprot, s.awaddr[1:0], s.araddr[1:0]};

    // Readies stay low through reset and rise on the first edge after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // AW and W holding slots fill independently and drain together on commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit)     aw_full <= 1'b0;
            else if (aw_hs) aw_full <= 1'b1;
            if (aw_hs)      aw_idx  <= s.awaddr[ADDR_WIDTH-1:2];
            if (commit)     w_full  <= 1'b0;
            else if (w_hs)  w_full  <= 1'b1;
            if (w_hs) begin
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
        end
    end

    // Write response is raised on commit and held until the master takes it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s.bvalid <= 1'b0;
            s.bresp  <= RESP_OKAY;
        end else if (commit) begin
            s.bvalid <= 1'b1;
            s.bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s.bvalid && s.bready) begin
            s.bvalid <= 1'b0;
        end
    end

    // Register bank; out-of-range commits leave it untouched.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && aw_ok) begin
            regs[aw_idx[IW-1:0]] <= strb_merge(regs[aw_idx[IW-1:0]], w_data, w_strb);
        end
    end

    // Read data is captured at AR acceptance, so a same-edge commit is seen only by later reads.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s.rvalid <= 1'b0;
            s.rdata  <= '0;
            s.rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s.rvalid <= 1'b1;
            s.rdata  <= ar_ok ? regs[ar_idx[IW-1:0]] : '0;
            s.rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s.rvalid && s.rready) begin
            s.rvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_o[32*i +: 32] = regs[i];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: directed self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [255:0] regs_o;
    logic [255:0] snap;
    int           checks = 0;
    int           errors = 0;

    axi_lite_if bus ();

    axi_lite_regfile #(.NUM_REGS(8)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s       (bus),
        .regs_o  (regs_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return regs_o[32*i +: 32];
    endfunction

    task automatic put_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = st;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic b_ack();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic r_ack();
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        ARESETN     = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (2) tick();
        chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_regs", regs_o, '0);
        ARESETN = 1'b1;
        #1;
        chk("rel_readies_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        chk("rel_readies_high", {bus.awready, bus.wready, bus.arready}, 3'b111);

        bus.awaddr  = 32'h8;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("aw_buffered", {bus.awready, bus.wready}, 2'b01);
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_outs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata}, '0);
        chk("mid_rst_regs", regs_o, '0);
        ARESETN = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_b", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
        chk("post_rst_regs", regs_o, '0);

        chk("basic_ready", {bus.awready, bus.wready}, 2'b11);
        put_aw_w(32'h8, 32'hDEADBEEF, 4'hF);
        chk("basic_b_not_yet", {bus.bvalid, bus.awready, bus.wready}, 3'b000);
        tick();
        chk("basic_b", {bus.bvalid, bus.bresp}, 3'b100);
        chk("basic_reg2", reg_at(2), 32'hDEADBEEF);
        b_ack();
        chk("basic_b_clr", bus.bvalid, 1'b0);
        bus.araddr  = 32'h8;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("basic_r", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {1'b1, 1'b0, 2'b00, 32'hDEADBEEF});
        r_ack();
        chk("basic_r_clr", {bus.rvalid, bus.arready}, 2'b01);

        bus.wdata  = 32'h11223344;
        bus.wstrb  = 4'b0101;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("wfirst_0", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
        tick();
        chk("wfirst_1", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
        tick();
        chk("wfirst_2", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
        bus.awaddr  = 32'h8;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("wfirst_aw_in", {bus.awready, bus.wready, bus.bvalid}, 3'b000);
        tick();
        chk("wfirst_commit", {bus.bvalid, bus.bresp, bus.wready}, 4'b1001);
        chk("wfirst_reg2", reg_at(2), 32'hDE22BE44);
        b_ack();

        snap = regs_o;
        put_aw_w(32'h40, 32'hFFFFFFFF, 4'hF);
        tick();
        chk("oor_b", {bus.bvalid, bus.bresp}, 3'b110);
        chk("oor_regs", regs_o, snap);
        b_ack();
        bus.araddr  = 32'h40;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("oor_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, 2'b10, 32'h0});
        r_ack();

        put_aw_w(32'h4, 32'h01010101, 4'hF);
        tick();
        chk("bp_b1", {bus.bvalid, bus.bresp}, 3'b100);
        put_aw_w(32'h10, 32'h44444444, 4'hF);
        chk("bp_second_in", {bus.awready, bus.wready, bus.bvalid, bus.bresp}, 5'b00100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold", {bus.bvalid, bus.bresp, reg_at(4)}, {3'b100, 32'h0});
        end
        b_ack();
        chk("bp_b1_clr", {bus.bvalid, reg_at(4)}, {1'b0, 32'h0});
        tick();
        chk("bp_b2", {bus.bvalid, bus.bresp, reg_at(4)}, {3'b100, 32'h44444444});
        b_ack();

        bus.araddr  = 32'h4;
        bus.arvalid = 1'b1;
        tick();
        bus.araddr  = 32'h10;
        for (int i = 0; i < 4; i++) begin
            chk("rbp_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {2'b10, 2'b00, 32'h01010101});
            tick();
        end
        r_ack();
        chk("rbp_clr", {bus.rvalid, bus.arready}, 2'b01);
        tick();
        bus.arvalid = 1'b0;
        chk("rbp_second", {bus.rvalid, bus.rdata}, {1'b1, 32'h44444444});
        r_ack();

        chk("same_pre", reg_at(3), 32'h0);
        put_aw_w(32'hC, 32'hA5A5A5A5, 4'hF);
        bus.araddr  = 32'hC;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("same_edge_r", {bus.rvalid, bus.rdata}, {1'b1, 32'h0});
        chk("same_edge_w", {bus.bvalid, reg_at(3)}, {1'b1, 32'hA5A5A5A5});
        b_ack();
        r_ack();
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("same_after", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, 2'b00, 32'hA5A5A5A5});
        r_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite slave that terminates the `axi_lite_if` bus with a bank of `NUM_REGS` 32-bit read/write registers.
- Accepts AW and W independently and merges write data per WSTRB byte lane.
- Returns B and R responses with full valid/ready backpressure.
- Exposes all register contents to the fabric as a flat vector.
- Sits at the end of the bus as the control/status register target of a peripheral.

## Interface
Parameters:
- `NUM_REGS`, 8: number of 32-bit registers; byte address `4*i` maps to register `i`.

Ports:
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `s`  `axi_lite_if.slave`  —  AXI4-Lite bus, 32-bit address and data; all five channels.
- `regs_o`  out  `NUM_REGS*32`  register contents; register `i` at bits `[32*i +: 32]`.

## Operation
**Address decode**
- Register index is `ADDR[31:2]`.
- `ADDR[1:0]` and `AWPROT`/`ARPROT` are ignored.
- Index `>= NUM_REGS` is out of range.

**Write path**
- AW holding slot: captures `AWADDR` on `AWVALID && AWREADY`.
- W holding slot: captures `WDATA` and `WSTRB` on `WVALID && WREADY`.
- `AWREADY` is high exactly when the AW slot is empty; `WREADY` likewise for the W slot.
- The two slots fill in either order, or in the same cycle.
- Commit occurs on the edge where both slots are full and `BVALID == 0`. On that edge:
  - In range: byte lane `b` of the target register takes `WDATA[8b+7:8b]` only where `WSTRB[b] == 1`.
  - Out of range: the register bank is unchanged.
  - Both slots are cleared.
  - `BVALID` is set. `BRESP` is `OKAY` (2'b00) in range, `SLVERR` (2'b10) out of range.
- `BVALID` and `BRESP` hold stable until `BVALID && BREADY`; `BVALID` clears on that edge.
- While B is pending, a new AW/W pair may fill the slots; its commit waits until `BVALID` clears.

**Read path**
- `ARREADY = !RVALID`.
- On `ARVALID && ARREADY`, the same edge registers:
  - `RDATA`: the register value, or 0 when out of range.
  - `RRESP`: `OKAY` or `SLVERR`.
  - `RVALID` set to 1.
- `RVALID`, `RDATA` and `RRESP` hold stable until `RVALID && RREADY`.

**Read/write interaction**
- Read and write paths are independent.
- A read accepted on the same edge as a commit to the same register returns the pre-write value.

## Timing
**Reset**
- Asserting `ARESETN` low asynchronously clears: all registers, both slots, `BVALID`, `RVALID`, `RDATA`, `BRESP`, `RRESP`, and the ready outputs.
- All ready outputs are 0 while reset is asserted and go high on the first `ACLK` edge after deassertion.
- Reset mid-transaction discards buffered AW/W and pending B/R with no response issued.

**Latency**
- Write, AW and W handshaken on edge N: `BVALID` is high after edge N+1.
- Read, AR handshaken on edge N: `RVALID` is high after edge N.
- `RDATA` is valid one cycle after the AR handshake.

**Throughput and protocol**
- Sustained throughput is one write per 2 cycles with `BREADY` held high, and one read per 2 cycles.
- No combinational path from any VALID or READY input to any output.

## Structure
**Shared package `axi_lite_pkg`** holds:
- `ADDR_WIDTH` = 32, `DATA_WIDTH` = 32
- `resp_t` with `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10
- function `strb_merge(old, data, strb)`

**Interface**
- The `axi_lite_if` slave modport lists `WREADY` as an output.

**Modules**
- No sub-module. The block is a single module of about 150 lines: two holding slots, a commit condition, B and R output registers, and the register array.

## Test plan
- **Reset:** assert `ARESETN` mid-write with AW buffered → all outputs 0, no BVALID after release, `regs_o` all 0.
- **Basic write/read:** AW `0x8` and W `0xDEADBEEF`/`0xF` in the same cycle → `BVALID` 1 cycle later with `BRESP` 00. Then AR `0x8` → `RDATA` `0xDEADBEEF`, `RRESP` 00, one cycle after the handshake.
- **W before AW, partial strobe:** W `0x11223344`/`0b0101` arrives 3 cycles before AW `0x8` → `AWREADY` stays high and `WREADY` is low until commit. Register 2 becomes `0xDE22BE44`.
- **Out of range (`NUM_REGS` = 8):** write `0x40` → `SLVERR`, `regs_o` unchanged. Read `0x40` → `RDATA` 0, `RRESP` 10.
- **Backpressure:**
  - Hold `BREADY` low 5 cycles → `BVALID`/`BRESP` stable throughout. A second AW/W is accepted, but its commit and `BVALID` occur only after the first B handshake.
  - Hold `RREADY` low → `ARREADY` stays 0 and `RDATA` is stable.
- **Same-edge read/write:** read accepted on the commit edge for register 3 (old `0x0`, new `0xA5A5A5A5`) → `RDATA` `0x0`. A following read returns `0xA5A5A5A5`.
